snake_sequencer: RTL and testbench

SNAKE_SEQUENCER -- requirements
Module: snake_sequencer

---
 rtl/snake_sequencer_if.sv | 22 ++
 rtl/snake_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_snake_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_sequencer_if.sv
// Food-randomizer handshake and body-FIFO bus between the snake sequencer and its neighbours.
// master = sequencer side, slave = randomizer/FIFO side.
interface snake_sequencer_if;
    logic       food_req;
    logic       food_valid;
    logic [7:0] food_cand;
    logic       fifo_clr;
    logic       fifo_wr_req;
    logic       fifo_rd_req;
    logic [7:0] fifo_data;
    logic [7:0] fifo_q;

    modport master (
        output food_req, fifo_clr, fifo_wr_req, fifo_rd_req, fifo_data,
        input  food_valid, food_cand, fifo_q
    );

    modport slave (
        input  food_req, fifo_clr, fifo_wr_req, fifo_rd_req, fifo_data,
        output food_valid, food_cand, fifo_q
    );
endinterface

// File: rtl/snake_sequencer.sv
// Snake game sequencer: owns head/food/score state and an 8x16 occupancy bitmap
// that mirrors the body FIFO; body segments live in the external FIFO (tail = fifo_q).
module snake_sequencer #(
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [1:0]         dir,
    snake_sequencer_if.master  bus,
    output logic [7:0]         head_pos,
    output logic [7:0]         food_pos,
    input  logic [2:0]         pix_row,
    output logic [15:0]        pix_cols,
    output logic [6:0]         length,
    output logic [7:0]         score,
    output logic               game_over,
    output logic               won
);

    typedef enum logic [2:0] {IDLE, INIT, FOOD, RUN, STEP, DEAD, WON} state_t;
    typedef enum logic [1:0] {UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11} dir_t;

    state_t             state, nextState;
    dir_t               heading;
    logic [7:0]         headPos, foodPos, scoreR;
    logic [6:0]         len;
    logic               overR, wonR;
    logic [3:0]         initCol;
    logic [7:0][15:0]   bitmap;

    logic [7:0] nextHead;
    logic       wallHit, selfHit, died, eat, winMove, initLast, foodOk, reversal;

    assign initLast = (initCol == 4'(INIT_LEN - 1));
    assign foodOk   = bus.food_valid && !bus.food_cand[7]
                      && !bitmap[bus.food_cand[6:4]][bus.food_cand[3:0]];
    // Opposite directions share bit 1 and differ in bit 0.
    assign reversal = (dir[1] == heading[1]) && (dir[0] != heading[0]);

    always_comb begin
        nextHead = headPos;
        wallHit  = 1'b0;
        case (heading)
            UP: begin
                wallHit       = (headPos[6:4] == 3'd0);
                nextHead[6:4] = headPos[6:4] - 3'd1;
            end
            DOWN: begin
                wallHit       = (headPos[6:4] == 3'd7);
                nextHead[6:4] = headPos[6:4] + 3'd1;
            end
            LEFT: begin
                wallHit       = (headPos[3:0] == 4'd0);
                nextHead[3:0] = headPos[3:0] - 4'd1;
            end
            RIGHT: begin
                wallHit       = (headPos[3:0] == 4'd15);
                nextHead[3:0] = headPos[3:0] + 4'd1;
            end
            default: wallHit = 1'b0;
        endcase
        nextHead[7] = 1'b0;
    end

    // The tail cell vacates this step, so entering it is only a collision if something else is there.
    assign selfHit = bitmap[nextHead[6:4]][nextHead[3:0]] && (nextHead != bus.fifo_q);
    assign died    = wallHit || selfHit;
    assign eat     = (nextHead == foodPos);
    assign winMove = eat && (len == 7'(MAX_LEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE, DEAD, WON: if (start) nextState = INIT;
            INIT:            if (initLast) nextState = FOOD;
            FOOD:            if (foodOk) nextState = RUN;
            RUN:             if (tick) nextState = STEP;
            STEP: begin
                if (died)         nextState = DEAD;
                else if (winMove) nextState = WON;
                else if (eat)     nextState = FOOD;
                else              nextState = RUN;
            end
            default:         nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_clr    = !reset;
        bus.fifo_wr_req = 1'b0;
        bus.fifo_rd_req = 1'b0;
        bus.fifo_data   = '0;
        bus.food_req    = 1'b0;
        case (state)
            IDLE, DEAD, WON: if (start) bus.fifo_clr = 1'b1;
            INIT: begin
                bus.fifo_wr_req = 1'b1;
                bus.fifo_data   = {4'h0, initCol};
            end
            FOOD: bus.food_req = 1'b1;
            STEP: begin
                if (!died) begin
                    bus.fifo_wr_req = 1'b1;
                    bus.fifo_rd_req = !eat && (len != 7'd0);
                    bus.fifo_data   = nextHead;
                end
            end
            default: bus.fifo_clr = !reset;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            heading <= UP;
            headPos <= '0;
            foodPos <= '0;
            scoreR  <= '0;
            len     <= '0;
            overR   <= 1'b0;
            wonR    <= 1'b0;
            initCol <= '0;
            bitmap  <= '0;
        end else begin
            case (state)
                IDLE, DEAD, WON: begin
                    if (start) begin
                        bitmap  <= '0;
                        scoreR  <= '0;
                        len     <= '0;
                        overR   <= 1'b0;
                        wonR    <= 1'b0;
                        initCol <= '0;
                    end
                end
                INIT: begin
                    bitmap[0][initCol] <= 1'b1;
                    len                <= len + 7'd1;
                    initCol            <= initCol + 4'd1;
                    if (initLast) begin
                        headPos <= {4'h0, initCol};
                        heading <= RIGHT;
                    end
                end
                FOOD: if (foodOk) foodPos <= bus.food_cand;
                RUN:  if (tick && !reversal) heading <= dir_t'(dir);
                STEP: begin
                    if (died) begin
                        overR <= 1'b1;
                    end else begin
                        headPos <= nextHead;
                        // Clear-then-set order keeps the bit when the head moves into the tail cell.
                        if (!eat) bitmap[bus.fifo_q[6:4]][bus.fifo_q[3:0]] <= 1'b0;
                        bitmap[nextHead[6:4]][nextHead[3:0]] <= 1'b1;
                        if (eat) begin
                            len    <= len + 7'd1;
                            scoreR <= (scoreR == 8'hFF) ? scoreR : scoreR + 8'd1;
                        end
                        if (winMove) begin
                            wonR  <= 1'b1;
                            overR <= 1'b1;
                        end
                    end
                end
                default: overR <= overR;
            endcase
        end
    end

    assign head_pos  = headPos;
    assign food_pos  = foodPos;
    assign pix_cols  = bitmap[pix_row];
    assign length    = len;
    assign score     = scoreR;
    assign game_over = overR;
    assign won       = wonR;

endmodule

// File: tb/tb_snake_sequencer.sv
// Directed bench for snake_sequencer: a queue-based game model plus a behavioural body FIFO,
// compared against the DUT every settled cycle, with literal spot checks on key moves.
module tb_snake_sequencer;

    localparam int TB_INIT_LEN = 3;
    localparam int TB_MAX_LEN  = 6;
    localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;

    logic        clk = 1'b0;
    logic        reset, tick, start;
    logic [1:0]  dir;
    logic [2:0]  pixRow;
    logic [7:0]  head_pos, food_pos, score;
    logic [15:0] pix_cols;
    logic [6:0]  length;
    logic        game_over, won;

    snake_sequencer_if bus();

    snake_sequencer #(.INIT_LEN(TB_INIT_LEN), .MAX_LEN(TB_MAX_LEN)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .dir(dir), .bus(bus),
        .head_pos(head_pos), .food_pos(food_pos), .pix_row(pixRow), .pix_cols(pix_cols),
        .length(length), .score(score), .game_over(game_over), .won(won)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural body FIFO (show-ahead tail on fifo_q).
    logic [7:0] fifoMem[$];
    logic [7:0] tailQ;
    always @(posedge clk) begin
        if (bus.fifo_clr) fifoMem.delete();
        else begin
            if (bus.fifo_rd_req && fifoMem.size() > 0) void'(fifoMem.pop_front());
            if (bus.fifo_wr_req) fifoMem.push_back(bus.fifo_data);
        end
        tailQ <= (fifoMem.size() > 0) ? fifoMem[0] : 8'h00;
    end
    assign bus.fifo_q = tailQ;

    // Game model: body queue front = tail, back = head.
    logic [7:0] mBody[$];
    logic [7:0] mFood;
    logic [1:0] mHeading;
    int         mScore;
    bit         mOver, mWon, mNeedFood, mRun, mValid;

    function automatic bit occ(input logic [7:0] p);
        foreach (mBody[i]) if (mBody[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] rowBits(input logic [2:0] r);
        logic [15:0] b;
        b = '0;
        foreach (mBody[i]) if (mBody[i][6:4] == r) b[mBody[i][3:0]] = 1'b1;
        return b;
    endfunction

    function automatic logic [7:0] expHead();
        return (mBody.size() > 0) ? mBody[mBody.size()-1] : 8'h00;
    endfunction

    task automatic modelReset;
        mBody.delete();
        mFood = 8'h00; mHeading = D_UP; mScore = 0;
        mOver = 0; mWon = 0; mNeedFood = 0; mRun = 0;
    endtask

    task automatic compareAll;
        check("head_pos", 32'(head_pos), 32'(expHead()));
        check("length", 32'(length), 32'(mBody.size()));
        check("score", 32'(score), 32'(mScore));
        check("game_over", 32'(game_over), 32'(mOver));
        check("won", 32'(won), 32'(mWon));
        check("food_req", 32'(bus.food_req), 32'(mNeedFood));
        check("food_pos", 32'(food_pos), 32'(mFood));
        check("idle_wr", 32'(bus.fifo_wr_req), 32'd0);
        check("idle_rd", 32'(bus.fifo_rd_req), 32'd0);
        check("idle_clr", 32'(bus.fifo_clr), 32'd0);
        check("pix_cols", 32'(pix_cols), 32'(rowBits(pixRow)));
        check("fifo_size", 32'(fifoMem.size()), 32'(mBody.size()));
        for (int i = 0; i < fifoMem.size() && i < mBody.size(); i++)
            check("fifo_elem", 32'(fifoMem[i]), 32'(mBody[i]));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mValid) compareAll();
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pixRow = pixRow + 3'd1;
        end
    endtask

    task automatic doStart;
        logic [7:0] e;
        mValid = 0;
        @(negedge clk);
        start = 1'b1;
        #1;
        check("start_clr", 32'(bus.fifo_clr), 32'd1);
        for (int i = 0; i < TB_INIT_LEN; i++) begin
            @(negedge clk);
            start = 1'b0;
            e = 8'(i);
            check("init_wr", 32'(bus.fifo_wr_req), 32'd1);
            check("init_data", 32'(bus.fifo_data), 32'(e));
        end
        mBody.delete();
        for (int i = 0; i < TB_INIT_LEN; i++) mBody.push_back(8'(i));
        mHeading = D_RIGHT; mScore = 0; mOver = 0; mWon = 0; mNeedFood = 1; mRun = 0;
        mValid = 1;
    endtask

    task automatic offerFood(input logic [7:0] c);
        mValid = 0;
        @(negedge clk);
        bus.food_valid = 1'b1;
        bus.food_cand  = c;
        @(negedge clk);
        bus.food_valid = 1'b0;
        if (mNeedFood && !c[7] && !occ(c)) begin
            mFood = c; mNeedFood = 0; mRun = 1;
        end
        mValid = 1;
    endtask

    task automatic doTick(input logic [1:0] d, output logic wrSeen, output logic rdSeen);
        logic [7:0] h, nh;
        int r, c;
        bit live, opp, wall, eat, hit, wrExp, rdExp;
        mValid = 0;
        live = mRun;
        h = expHead();
        @(negedge clk);
        tick = 1'b1;
        dir  = d;
        @(negedge clk);
        tick = 1'b0;
        wrSeen = bus.fifo_wr_req;
        rdSeen = bus.fifo_rd_req;
        wall = 0; eat = 0; hit = 0; nh = 8'h00;
        if (live) begin
            opp = (mHeading == D_UP && d == D_DOWN) || (mHeading == D_DOWN && d == D_UP) ||
                  (mHeading == D_LEFT && d == D_RIGHT) || (mHeading == D_RIGHT && d == D_LEFT);
            if (!opp) mHeading = d;
            r = int'(h[6:4]);
            c = int'(h[3:0]);
            case (mHeading)
                D_UP:    r = r - 1;
                D_DOWN:  r = r + 1;
                D_LEFT:  c = c - 1;
                default: c = c + 1;
            endcase
            wall = (r < 0) || (r > 7) || (c < 0) || (c > 15);
            nh   = {1'b0, 3'(r), 4'(c)};
            eat  = !wall && (nh == mFood);
            hit  = !wall && !eat && occ(nh) && (nh != mBody[0]);
        end
        wrExp = live && !wall && !hit;
        rdExp = wrExp && !eat;
        check("step_wr", 32'(wrSeen), 32'(wrExp));
        check("step_rd", 32'(rdSeen), 32'(rdExp));
        if (wrExp) check("step_data", 32'(bus.fifo_data), 32'(nh));
        check("head_hold", 32'(head_pos), 32'(h));
        if (live) begin
            if (wall || hit) begin
                mOver = 1; mRun = 0;
            end else if (eat) begin
                mBody.push_back(nh);
                mScore = (mScore < 255) ? mScore + 1 : 255;
                mRun = 0;
                if (mBody.size() == TB_MAX_LEN) begin
                    mWon = 1; mOver = 1;
                end else mNeedFood = 1;
            end else begin
                void'(mBody.pop_front());
                mBody.push_back(nh);
            end
        end
        mValid = 1;
    endtask

    task automatic resetNow;
        #1 reset = 1'b0;
        #1;
        check("ar_clr", 32'(bus.fifo_clr), 32'd1);
        check("ar_wr", 32'(bus.fifo_wr_req), 32'd0);
        check("ar_rd", 32'(bus.fifo_rd_req), 32'd0);
        check("ar_food_req", 32'(bus.food_req), 32'd0);
        check("ar_len", 32'(length), 32'd0);
        check("ar_head", 32'(head_pos), 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        mValid = 1;
    endtask

    logic w, rd;

    initial begin
        reset = 1'b0; start = 1'b0; tick = 1'b0; dir = D_UP; pixRow = 3'd0;
        bus.food_valid = 1'b0; bus.food_cand = 8'h00;
        mValid = 0;
        modelReset();
        repeat (3) @(negedge clk);
        check("rst_fifo_clr", 32'(bus.fifo_clr), 32'd1);
        check("rst_food_req", 32'(bus.food_req), 32'd0);
        check("rst_wr", 32'(bus.fifo_wr_req), 32'd0);
        check("rst_rd", 32'(bus.fifo_rd_req), 32'd0);
        check("rst_head", 32'(head_pos), 32'd0);
        check("rst_len", 32'(length), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_over", 32'(game_over), 32'd0);
        check("rst_won", 32'(won), 32'd0);
        check("rst_pix", 32'(pix_cols), 32'd0);
        reset = 1'b1;
        mValid = 1;
        idle(3);

        // Game A: init, food rejection, reversal, wall
        doStart();
        idle(1);
        check("a_head", 32'(head_pos), 32'h02);
        check("a_len", 32'(length), 32'd3);
        check("a_food_req", 32'(bus.food_req), 32'd1);
        offerFood(8'h01);
        check("a_rej_occ", 32'(bus.food_req), 32'd1);
        offerFood(8'h85);
        check("a_rej_row", 32'(bus.food_req), 32'd1);
        offerFood(8'h45);
        idle(1);
        check("a_food_pos", 32'(food_pos), 32'h45);
        check("a_food_req_lo", 32'(bus.food_req), 32'd0);
        doTick(D_LEFT, w, rd);
        check("a_rev_wr", 32'(w), 32'd1);
        check("a_rev_rd", 32'(rd), 32'd1);
        idle(1);
        check("a_rev_head", 32'(head_pos), 32'h03);
        pixRow = 3'd0;
        #1;
        check("a_row0", 32'(pix_cols), 32'h000E);
        for (int i = 0; i < 12; i++) doTick(D_RIGHT, w, rd);
        idle(1);
        check("a_edge_head", 32'(head_pos), 32'h0F);
        doTick(D_RIGHT, w, rd);
        check("a_wall_wr", 32'(w), 32'd0);
        check("a_wall_rd", 32'(rd), 32'd0);
        idle(1);
        check("a_wall_over", 32'(game_over), 32'd1);
        doTick(D_DOWN, w, rd);
        check("a_dead_wr", 32'(w), 32'd0);
        idle(2);

        // Game B: eating, tail-chasing, mid-body collision
        doStart();
        offerFood(8'h04);
        doTick(D_RIGHT, w, rd);
        doTick(D_RIGHT, w, rd);
        check("b_eat_wr", 32'(w), 32'd1);
        check("b_eat_rd", 32'(rd), 32'd0);
        idle(1);
        check("b_eat_len", 32'(length), 32'd4);
        check("b_eat_score", 32'(score), 32'd1);
        check("b_eat_req", 32'(bus.food_req), 32'd1);
        offerFood(8'h04);
        offerFood(8'h05);
        doTick(D_DOWN, w, rd);
        doTick(D_LEFT, w, rd);
        doTick(D_UP, w, rd);
        idle(1);
        check("b_tail1_over", 32'(game_over), 32'd0);
        check("b_tail1_head", 32'(head_pos), 32'h03);
        doTick(D_RIGHT, w, rd);
        idle(1);
        check("b_tail2_head", 32'(head_pos), 32'h04);
        doTick(D_RIGHT, w, rd);
        idle(1);
        check("b_len5", 32'(length), 32'd5);
        check("b_score2", 32'(score), 32'd2);
        offerFood(8'h7F);
        doTick(D_DOWN, w, rd);
        doTick(D_LEFT, w, rd);
        doTick(D_UP, w, rd);
        check("b_self_wr", 32'(w), 32'd0);
        idle(1);
        check("b_self_over", 32'(game_over), 32'd1);
        check("b_self_head", 32'(head_pos), 32'h14);
        idle(2);

        // Game C: fill to MAX_LEN
        doStart();
        offerFood(8'h03);
        doTick(D_RIGHT, w, rd);
        offerFood(8'h04);
        doTick(D_RIGHT, w, rd);
        offerFood(8'h05);
        doTick(D_RIGHT, w, rd);
        check("c_win_wr", 32'(w), 32'd1);
        idle(1);
        check("c_won", 32'(won), 32'd1);
        check("c_over", 32'(game_over), 32'd1);
        check("c_len", 32'(length), 32'd6);
        check("c_score", 32'(score), 32'd3);
        doTick(D_DOWN, w, rd);
        idle(2);

        // Reset during STEP, then during INIT
        doStart();
        offerFood(8'h7F);
        mValid = 0;
        @(negedge clk);
        tick = 1'b1;
        dir  = D_RIGHT;
        @(negedge clk);
        tick = 1'b0;
        check("d_step_wr", 32'(bus.fifo_wr_req), 32'd1);
        resetNow();
        idle(3);
        mValid = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("d_init_wr", 32'(bus.fifo_wr_req), 32'd1);
        resetNow();
        idle(3);

        mValid = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
